// File: rtl/qlen_trr_if.sv
// qlen_trr_if: valid/ready/data stream interface (dti) used by qlen_trr
//   valid : producer -> consumer, data is meaningful
//   ready : consumer -> producer, consumer accepts this cycle
//   data  : W-bit payload; for eot-delimited streams data[W-1] is eot
interface dti #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/qlen_trr.sv
// qlen_trr: buffers an eot-delimited stream in a FIFO and reports each transaction's length
//   clk  : clock, all state updates on rising edge
//   rst  : asynchronous active-low reset
//   din  : dti.consumer, W bits, data[W-1] = eot, data[W-2:0] = payload
//   dout : dti.producer, W bits, buffered copy of din (eot included)
//   len  : dti.producer, LEN_W bits, element count of each completed transaction
//   Optional macro QLEN_TRR_SAT_EN: saturate the element counter instead of wrapping.
module qlen_trr #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic  clk,
    input  logic  rst,
    dti.consumer  din,
    dti.producer  dout,
    dti.producer  len
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [LEN_W-1:0] cnt_reg;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_reg;
    logic             len_vld;
    logic             full;
    logic             empty;
    logic             din_eot;
    logic             push;
    logic             pop;
    logic             len_pop;

    // Pointers carry an extra wrap bit: equal means empty, differing only in the MSB means full.
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign din_eot = din.data[W-1];

    // An eot may only enter when the length register is free or emptying this cycle.
    assign din.ready = !full && !(din_eot && len_vld && !len.ready);
    assign push      = din.valid && din.ready;
    assign pop       = dout.valid && dout.ready;
    assign len_pop   = len_vld && len.ready;

    assign dout.valid = !empty;
    assign dout.data  = mem[rd_ptr[AW-1:0]];
    assign len.valid  = len_vld;
    assign len.data   = len_reg;

`ifdef QLEN_TRR_SAT_EN
    assign cnt_inc = &cnt_reg ? cnt_reg : cnt_reg + LEN_W'(1);
`else
    assign cnt_inc = cnt_reg + LEN_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din.data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt_reg <= '0;
            len_reg <= '0;
            len_vld <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push) cnt_reg <= din_eot ? '0 : cnt_inc;
            if (push && din_eot) begin
                len_reg <= cnt_inc;
                len_vld <= 1'b1;
            end else if (len_pop) begin
                len_vld <= 1'b0;
            end
        end
    end
endmodule
